// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl -- multi-cycle MIPS control unit.
// Moore-style state machine sequencing fetch, decode, memory, ALU, branch and
// jump steps. Datapath controls are decoded from the current state; only the
// memory handshake (mem_ready) and the ALU zero flag qualify them.
// A per-state wait counter bounds memory stalls. On expiry the instruction is
// abandoned, the sticky mem_err flag is raised and the machine re-fetches.
// Optional feature: define MIPS_MC_CTRL_BNE_EN to add bne (opcode 000101).
// Without it, bne decodes as an illegal opcode.
module mips_mc_ctrl #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic [3:0] state,
  output logic       illegal_op,
  output logic       mem_err
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MIPS_MC_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

  // R-type funct decode: bit 3 = supported, bits 2:0 = ALU operation.
  // Unsupported functs fall back to add so the datapath stays well-defined.
  function automatic logic [3:0] funct_decode(input logic [5:0] f);
    logic [3:0] r;
    case (f)
      6'b100000: r = {1'b1, 3'b010};
      6'b100010: r = {1'b1, 3'b110};
      6'b100100: r = {1'b1, 3'b000};
      6'b100101: r = {1'b1, 3'b001};
      6'b101010: r = {1'b1, 3'b111};
      default:   r = {1'b0, 3'b010};
    endcase
    return r;
  endfunction

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_err_q, mem_err_d;
  logic       illegal_op_q, illegal_op_d;
  logic       mem_phase_s;
  logic       timeout_s;
  logic [3:0] funct_dec_s;

  // Memory-access states: the only states where mem_ready is honoured
  assign mem_phase_s = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  // Timeout fires only if the memory is still not ready on the last allowed cycle
  assign timeout_s   = mem_phase_s && !mem_ready && (wait_cnt_q == WAIT_MAX);
  assign funct_dec_s = funct_decode(funct);
  assign mem_err_d   = mem_err_q | timeout_s;

  // Next-state decode and illegal-instruction detection
  always_comb begin
    state_d      = state_q;
    illegal_op_d = 1'b0;
    case (state_q)
      S_FETCH: begin
        // A fetch timeout simply stays here; pc_en was never raised so the PC is unchanged
        if (mem_ready) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MIPS_MC_CTRL_BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d      = S_FETCH;
            illegal_op_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_MEMRD;
        end
      end
      S_MEMRD: begin
        // mem_ready wins over a coincident timeout
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (timeout_s) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_MEMRD;
        end
      end
      S_MEMWR: begin
        if (mem_ready || timeout_s) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_MEMWR;
        end
      end
      S_EXEC: begin
        state_d      = S_ALUWB;
        illegal_op_d = ~funct_dec_s[3];
      end
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Wait counter: counts stalled memory cycles, restarts on every state change or timeout
  always_comb begin
    if ((state_d != state_q) || timeout_s) begin
      wait_cnt_d = 8'd0;
    end else if (mem_phase_s && !mem_ready && (wait_cnt_q != 8'hFF)) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // State, wait counter and status flags with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      wait_cnt_q   <= 8'd0;
      mem_err_q    <= 1'b0;
      illegal_op_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      mem_err_q    <= mem_err_d;
      illegal_op_q <= illegal_op_d;
    end
  end

  // Datapath control decode; during reset present the quiescent fetch controls with no writes
  always_comb begin
    mem_req     = 1'b0;
    iord        = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_en       = 1'b0;
    pc_src      = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = 3'b000;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    state       = state_q;
    illegal_op  = illegal_op_q;
    mem_err     = mem_err_q;
    if (rst) begin
      mem_req     = 1'b1;
      alu_src_b   = 2'b01;
      alu_control = 3'b010;
      state       = S_FETCH;
      illegal_op  = 1'b0;
      mem_err     = 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          // ir_write/pc_en need mem_ready, so a timeout cycle can never write
          mem_req     = 1'b1;
          alu_src_b   = 2'b01;
          alu_control = 3'b010;
          ir_write    = mem_ready;
          pc_en       = mem_ready;
        end
        S_DECODE: begin
          alu_src_b   = 2'b11;
          alu_control = 3'b010;
        end
        S_MEMADR, S_ADDIEX: begin
          alu_src_a   = 1'b1;
          alu_src_b   = 2'b10;
          alu_control = 3'b010;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEMWR: begin
          mem_req   = 1'b1;
          iord      = 1'b1;
          mem_write = ~timeout_s;
        end
        S_MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
        end
        S_EXEC: begin
          alu_src_a   = 1'b1;
          alu_control = funct_dec_s[2:0];
        end
        S_ALUWB: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a   = 1'b1;
          alu_control = 3'b110;
          pc_src      = 2'b01;
`ifdef MIPS_MC_CTRL_BNE_EN
          pc_en       = (opcode == OP_BNE) ? ~zero : zero;
`else
          pc_en       = zero;
`endif
        end
        S_ADDIWB: begin
          reg_write = 1'b1;
        end
        S_JUMP: begin
          pc_src = 2'b10;
          pc_en  = 1'b1;
        end
        default: begin
          mem_req = 1'b0;
        end
      endcase
    end
  end

endmodule
